// File: rtl/shifter_pkg.sv
// Shared FSM state type and default geometry for the serial and barrel shifters.
// Optional rotate support is enabled with the SHIFTER_SERIAL_ROTATE_EN macro.
package shifter_pkg;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_SHAMT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shifter_serial_shift_step.sv
// Combinational single-bit left/right step with zero fill.
// SHIFTER_SERIAL_ROTATE_EN adds a rotate input that refills with the bit shifted out.
module shift_step #(
    parameter int unsigned WIDTH = shifter_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
`ifdef SHIFTER_SERIAL_ROTATE_EN
    input  logic             rotate_i,
`endif
    input  logic             left_i,
    output logic [WIDTH-1:0] data_o
);

    logic fill_left;
    logic fill_right;

`ifdef SHIFTER_SERIAL_ROTATE_EN
    assign fill_left  = rotate_i & data_i[WIDTH-1];
    assign fill_right = rotate_i & data_i[0];
`else
    assign fill_left  = 1'b0;
    assign fill_right = 1'b0;
`endif

    always_comb begin
        if (left_i) begin
            data_o = {data_i[WIDTH-2:0], fill_left};
        end else begin
            data_o = {fill_right, data_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shifter_serial.sv
// Serial shifter: one bit per cycle, done pulse after shamt+1 cycles.
// SHIFTER_SERIAL_ROTATE_EN adds the rotate input (latched together with start).
module shifter_serial
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               leftRight,
`ifdef SHIFTER_SERIAL_ROTATE_EN
    input  logic               rotate,
`endif
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   sftSrc,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic               left_q, left_d;
    logic [WIDTH-1:0]   step_out;
`ifdef SHIFTER_SERIAL_ROTATE_EN
    logic               rot_q, rot_d;
`endif

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i   (work_q),
`ifdef SHIFTER_SERIAL_ROTATE_EN
        .rotate_i (rot_q),
`endif
        .left_i   (left_q),
        .data_o   (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            left_q  <= 1'b0;
`ifdef SHIFTER_SERIAL_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            left_q  <= left_d;
`ifdef SHIFTER_SERIAL_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        left_d  = left_q;
`ifdef SHIFTER_SERIAL_ROTATE_EN
        rot_d   = rot_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = sftSrc;
                    cnt_d   = shamt;
                    left_d  = leftRight;
`ifdef SHIFTER_SERIAL_ROTATE_EN
                    rot_d   = rotate;
`endif
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = step_out;
                cnt_d  = cnt_q - 1'b1;
                // Leave on the step that takes the counter from 1 to 0.
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = work_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_shifter_serial.sv
// Directed and random bench for shifter_serial with a result scoreboard.
// Build with SHIFTER_SERIAL_ROTATE_EN to also exercise rotate mode.
module tb_shifter_serial;

    localparam int unsigned W  = 16;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          leftRight;
    logic [SW-1:0] shamt;
    logic [W-1:0]  sftSrc;
    logic [W-1:0]  result;
    logic          busy;
    logic          done;
`ifdef SHIFTER_SERIAL_ROTATE_EN
    logic          rotate;
`endif

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  sb[$];

    always #5 clk = ~clk;

    shifter_serial #(
        .WIDTH   (W),
        .SHAMT_W (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .leftRight (leftRight),
`ifdef SHIFTER_SERIAL_ROTATE_EN
        .rotate    (rotate),
`endif
        .shamt     (shamt),
        .sftSrc    (sftSrc),
        .result    (result),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic left, input logic [SW-1:0] amt,
                                           input logic [W-1:0] src, input logic rot);
        logic [W-1:0] r;
        r = left ? (src << amt) : (src >> amt);
        if (rot && amt != '0) begin
            r = left ? (r | (src >> (W - amt))) : (r | (src << (W - amt)));
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // inject > 0 drives a spurious start (all-ones operand) in that cycle of the operation.
    task automatic run_op(input string tag, input logic left, input logic [SW-1:0] amt,
                          input logic [W-1:0] src, input logic rot, input int inject);
        int           first;
        int           ndone;
        logic [W-1:0] exp;
        first = 0;
        ndone = 0;
        exp   = model(left, amt, src, rot);
        leftRight = left;
        shamt     = amt;
        sftSrc    = src;
`ifdef SHIFTER_SERIAL_ROTATE_EN
        rotate    = rot;
`endif
        start = 1'b1;
        sb.push_back(exp);
        step();
        for (int c = 1; c <= int'(amt) + 3; c++) begin
            start = (inject > 0 && c == inject);
            if (start) begin
                sftSrc    = '1;
                leftRight = ~left;
                shamt     = '1;
            end else begin
                sftSrc    = W'($urandom);
                leftRight = 1'($urandom);
                shamt     = SW'($urandom);
            end
            check({tag, ":busy"}, busy, (c <= int'(amt) + 1));
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = c;
                    check({tag, ":sb"}, sb.size(), 1);
                    if (sb.size() > 0) check({tag, ":result"}, result, sb.pop_front());
                end
            end
            step();
        end
        start = 1'b0;
        check({tag, ":done_cycle"}, first, int'(amt) + 1);
        check({tag, ":done_count"}, ndone, 1);
        check({tag, ":hold"}, result, exp);
    endtask

    initial begin
        int ndone;
        rst_n     = 1'b0;
        start     = 1'b0;
        leftRight = 1'b0;
        shamt     = '0;
        sftSrc    = '0;
`ifdef SHIFTER_SERIAL_ROTATE_EN
        rotate    = 1'b0;
`endif
        #12;
        check("rst:result", result, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("left4", 1'b1, 4'd4, 16'h0001, 1'b0, 0);
        check("left4:value", result, 16'h0010);
        run_op("right15", 1'b0, 4'd15, 16'h8000, 1'b0, 0);
        check("right15:value", result, 16'h0001);
        run_op("zero", 1'b1, 4'd0, 16'hBEEF, 1'b0, 0);
        check("zero:value", result, 16'hBEEF);
        run_op("ignore", 1'b1, 4'd4, 16'h0001, 1'b0, 2);
        check("ignore:value", result, 16'h0010);

        // Abort a shamt=8 operation in its third cycle.
        leftRight = 1'b1;
        shamt     = 4'd8;
        sftSrc    = 16'hFFFF;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort:result", result, 0);
        check("abort:busy", busy, 0);
        check("abort:done", done, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (done) ndone++;
        end
        check("abort:no_done", ndone, 0);
        check("abort:idle", busy, 0);
        run_op("after_rst", 1'b0, 4'd3, 16'hA5A5, 1'b0, 0);

`ifdef SHIFTER_SERIAL_ROTATE_EN
        run_op("rot1", 1'b1, 4'd1, 16'h8001, 1'b1, 0);
        check("rot1:value", result, 16'h0003);
`endif

        for (int i = 0; i < 24; i++) begin
            logic rot;
            rot = 1'b0;
`ifdef SHIFTER_SERIAL_ROTATE_EN
            rot = 1'($urandom);
`endif
            run_op("rand", 1'($urandom), SW'($urandom_range(0, 15)), W'($urandom), rot, 0);
        end

        check("sb:empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
